// File: rtl/parking_lot_occupancy_if.sv
// rtl/parking_lot_occupancy_if.sv - sensor/status bundle for the parking lot occupancy tracker
// Optional statistics outputs are present when PARKING_LOT_STATS_EN is defined.
interface parking_lot_occupancy_if #(
    parameter int LANES = 2,
    parameter int WIDTH = 5
);
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;
    logic [LANES-1:0] lane_enter;
    logic [LANES-1:0] lane_exit;
    logic             rejected;
`ifdef PARKING_LOT_STATS_EN
    logic [15:0]      total_entries;
    logic [15:0]      total_exits;

    modport master (
        output a, b,
        input  count, full, empty, lane_enter, lane_exit, rejected, total_entries, total_exits
    );
    modport slave (
        input  a, b,
        output count, full, empty, lane_enter, lane_exit, rejected, total_entries, total_exits
    );
`else
    modport master (
        output a, b,
        input  count, full, empty, lane_enter, lane_exit, rejected
    );
    modport slave (
        input  a, b,
        output count, full, empty, lane_enter, lane_exit, rejected
    );
`endif
endinterface

// File: rtl/parking_lot_occupancy.sv
// rtl/parking_lot_occupancy.sv - per-lane gate direction FSMs feeding a saturating occupancy counter
// Define PARKING_LOT_STATS_EN to add the total_entries/total_exits counters.
module parking_lot_occupancy #(
    parameter int CAPACITY = 25,
    parameter int LANES    = 2,
    parameter int WIDTH    = $clog2(CAPACITY+1)
) (
    input  logic                      clk,
    input  logic                      reset,
    parking_lot_occupancy_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

    localparam logic signed [WIDTH+1:0] CAP_S = (WIDTH+2)'(CAPACITY);
    localparam logic [WIDTH-1:0]        CAP_W = WIDTH'(CAPACITY);

    state_t                  state_q   [LANES];
    state_t                  state_nxt [LANES];
    logic [LANES-1:0]        enter_evt;
    logic [LANES-1:0]        exit_evt;
    logic [LANES-1:0]        enter_q;
    logic [LANES-1:0]        exit_q;
    logic [WIDTH-1:0]        count_q;
    logic [WIDTH-1:0]        count_nxt;
    logic                    rejected_q;
    logic                    rejected_nxt;
    logic signed [WIDTH+1:0] n_enter;
    logic signed [WIDTH+1:0] n_exit;
    logic signed [WIDTH+1:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < LANES; i++) state_q[i] <= state_nxt[i];
        end
    end

    // Exit states mirror the entry states with a and b swapped.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            state_nxt[i] = IDLE;
            case (state_q[i])
                IDLE: case ({bus.a[i], bus.b[i]})
                    2'b10:   state_nxt[i] = EN1;
                    2'b01:   state_nxt[i] = EX1;
                    default: state_nxt[i] = IDLE;
                endcase
                EN1: case ({bus.a[i], bus.b[i]})
                    2'b11:   state_nxt[i] = EN2;
                    2'b10:   state_nxt[i] = EN1;
                    default: state_nxt[i] = IDLE;
                endcase
                EN2: case ({bus.a[i], bus.b[i]})
                    2'b01:   state_nxt[i] = EN3;
                    2'b10:   state_nxt[i] = EN1;
                    2'b11:   state_nxt[i] = EN2;
                    default: state_nxt[i] = IDLE;
                endcase
                EN3: case ({bus.a[i], bus.b[i]})
                    2'b11:   state_nxt[i] = EN2;
                    2'b01:   state_nxt[i] = EN3;
                    default: state_nxt[i] = IDLE;
                endcase
                EX1: case ({bus.a[i], bus.b[i]})
                    2'b11:   state_nxt[i] = EX2;
                    2'b01:   state_nxt[i] = EX1;
                    default: state_nxt[i] = IDLE;
                endcase
                EX2: case ({bus.a[i], bus.b[i]})
                    2'b10:   state_nxt[i] = EX3;
                    2'b01:   state_nxt[i] = EX1;
                    2'b11:   state_nxt[i] = EX2;
                    default: state_nxt[i] = IDLE;
                endcase
                EX3: case ({bus.a[i], bus.b[i]})
                    2'b11:   state_nxt[i] = EX2;
                    2'b10:   state_nxt[i] = EX3;
                    default: state_nxt[i] = IDLE;
                endcase
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            enter_evt[i] = (state_q[i] == EN3) && ({bus.a[i], bus.b[i]} == 2'b00);
            exit_evt[i]  = (state_q[i] == EX3) && ({bus.a[i], bus.b[i]} == 2'b00);
        end
    end

    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int i = 0; i < LANES; i++) begin
            n_enter = n_enter + (WIDTH+2)'(enter_evt[i]);
            n_exit  = n_exit  + (WIDTH+2)'(exit_evt[i]);
        end
        sum          = $signed({2'b00, count_q}) + n_enter - n_exit;
        rejected_nxt = 1'b0;
        count_nxt    = sum[WIDTH-1:0];
        if (sum < 0) begin
            count_nxt    = '0;
            rejected_nxt = 1'b1;
        end else if (sum > CAP_S) begin
            count_nxt    = CAP_W;
            rejected_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rejected_q <= 1'b0;
            enter_q    <= '0;
            exit_q     <= '0;
        end else begin
            count_q    <= count_nxt;
            rejected_q <= rejected_nxt;
            enter_q    <= enter_evt;
            exit_q     <= exit_evt;
        end
    end

    assign bus.count      = count_q;
    assign bus.full       = (count_q == CAP_W);
    assign bus.empty      = (count_q == '0);
    assign bus.lane_enter = enter_q;
    assign bus.lane_exit  = exit_q;
    assign bus.rejected   = rejected_q;

`ifdef PARKING_LOT_STATS_EN
    logic [15:0] total_entries_q;
    logic [15:0] total_exits_q;

    // Counts every FSM event, including those the clamp absorbed; wraps at 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_entries_q <= '0;
            total_exits_q   <= '0;
        end else begin
            total_entries_q <= total_entries_q + 16'(n_enter);
            total_exits_q   <= total_exits_q   + 16'(n_exit);
        end
    end

    assign bus.total_entries = total_entries_q;
    assign bus.total_exits   = total_exits_q;
`endif
endmodule

// File: tb/tb_parking_lot_occupancy.sv
// tb/tb_parking_lot_occupancy.sv - directed self-checking bench for parking_lot_occupancy
module tb_parking_lot_occupancy;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    parking_lot_occupancy_if #(.LANES(2), .WIDTH(5)) intf ();

    parking_lot_occupancy #(.CAPACITY(25), .LANES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic [1:0] av, input logic [1:0] bv);
        intf.a = av;
        intf.b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic enter_both();
        step(2'b11, 2'b00);
        step(2'b11, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b00);
    endtask

    task automatic exit_both();
        step(2'b00, 2'b11);
        step(2'b11, 2'b11);
        step(2'b11, 2'b00);
        step(2'b00, 2'b00);
    endtask

    task automatic exit_lane0();
        step(2'b00, 2'b01);
        step(2'b01, 2'b01);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step(2'b00, 2'b00);
        reset = 1'b0;
        step(2'b00, 2'b00);
        tests++; if (intf.count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", intf.count); end
        tests++; if (intf.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", intf.empty); end
        tests++; if (intf.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", intf.full); end
        tests++; if ({intf.lane_enter, intf.lane_exit, intf.rejected} !== 5'b0) begin
            fails++; $display("FAIL reset_pulses got %b want 00000", {intf.lane_enter, intf.lane_exit, intf.rejected});
        end
    endtask

    task automatic test_enter();
        logic [1:0] seq [3];
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step({1'b0, seq[i][1]}, {1'b0, seq[i][0]});
            tests++; if (intf.lane_enter !== 2'b00) begin fails++; $display("FAIL enter_early step %0d got %b want 00", i, intf.lane_enter); end
        end
        step(2'b00, 2'b00);
        tests++; if (intf.lane_enter !== 2'b01) begin fails++; $display("FAIL enter_pulse got %b want 01", intf.lane_enter); end
        tests++; if (intf.count !== 5'd1) begin fails++; $display("FAIL enter_count got %0d want 1", intf.count); end
        tests++; if (intf.empty !== 1'b0) begin fails++; $display("FAIL enter_empty got %b want 0", intf.empty); end
        step(2'b00, 2'b00);
        tests++; if (intf.lane_enter !== 2'b00) begin fails++; $display("FAIL enter_single got %b want 00", intf.lane_enter); end
    endtask

    task automatic test_abort_and_underflow();
        exit_lane0();
        tests++; if (intf.lane_exit !== 2'b01 || intf.count !== 5'd0 || intf.rejected !== 1'b0) begin
            fails++; $display("FAIL exit_normal got exit=%b count=%0d rej=%b want 01/0/0", intf.lane_exit, intf.count, intf.rejected);
        end
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        tests++; if (intf.lane_enter !== 2'b00 || intf.count !== 5'd0) begin
            fails++; $display("FAIL backout got enter=%b count=%0d want 00/0", intf.lane_enter, intf.count);
        end
        exit_lane0();
        tests++; if (intf.lane_exit !== 2'b01) begin fails++; $display("FAIL underflow_pulse got %b want 01", intf.lane_exit); end
        tests++; if (intf.count !== 5'd0) begin fails++; $display("FAIL underflow_count got %0d want 0", intf.count); end
        tests++; if (intf.rejected !== 1'b1) begin fails++; $display("FAIL underflow_rejected got %b want 1", intf.rejected); end
        step(2'b00, 2'b00);
        tests++; if (intf.rejected !== 1'b0) begin fails++; $display("FAIL rejected_one_cycle got %b want 0", intf.rejected); end
    endtask

    task automatic test_full();
        repeat (12) enter_both();
        tests++; if (intf.count !== 5'd24 || intf.rejected !== 1'b0 || intf.full !== 1'b0) begin
            fails++; $display("FAIL fill_24 got count=%0d rej=%b full=%b want 24/0/0", intf.count, intf.rejected, intf.full);
        end
        enter_both();
        tests++; if (intf.count !== 5'd25) begin fails++; $display("FAIL full_count got %0d want 25", intf.count); end
        tests++; if (intf.full !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", intf.full); end
        tests++; if (intf.rejected !== 1'b1 || intf.lane_enter !== 2'b11) begin
            fails++; $display("FAIL full_rejected got rej=%b enter=%b want 1/11", intf.rejected, intf.lane_enter);
        end
    endtask

    task automatic test_back_to_back();
        repeat (7) exit_both();
        exit_lane0();
        tests++; if (intf.count !== 5'd10) begin fails++; $display("FAIL drain_10 got %0d want 10", intf.count); end
        step(2'b01, 2'b10);
        step(2'b11, 2'b11);
        step(2'b10, 2'b01);
        step(2'b00, 2'b00);
        tests++; if (intf.count !== 5'd10) begin fails++; $display("FAIL cancel_count got %0d want 10", intf.count); end
        tests++; if (intf.lane_enter !== 2'b01 || intf.lane_exit !== 2'b10) begin
            fails++; $display("FAIL cancel_pulses got enter=%b exit=%b want 01/10", intf.lane_enter, intf.lane_exit);
        end
        tests++; if (intf.rejected !== 1'b0) begin fails++; $display("FAIL cancel_rejected got %b want 0", intf.rejected); end
    endtask

    task automatic test_reset_mid_sequence();
        step(2'b10, 2'b00);
        step(2'b10, 2'b10);
        reset = 1'b1;
        step(2'b10, 2'b10);
        reset = 1'b0;
        tests++; if (intf.count !== 5'd0 || intf.empty !== 1'b1) begin
            fails++; $display("FAIL midreset_count got count=%0d empty=%b want 0/1", intf.count, intf.empty);
        end
        step(2'b10, 2'b10);
        step(2'b10, 2'b10);
        step(2'b00, 2'b00);
        tests++; if (intf.lane_enter !== 2'b00 || intf.count !== 5'd0) begin
            fails++; $display("FAIL midreset_noevent got enter=%b count=%0d want 00/0", intf.lane_enter, intf.count);
        end
        step(2'b10, 2'b00);
        step(2'b10, 2'b10);
        step(2'b00, 2'b10);
        step(2'b00, 2'b00);
        tests++; if (intf.lane_enter !== 2'b10 || intf.count !== 5'd1) begin
            fails++; $display("FAIL midreset_enter got enter=%b count=%0d want 10/1", intf.lane_enter, intf.count);
        end
`ifdef PARKING_LOT_STATS_EN
        tests++; if (intf.total_entries !== 16'd1 || intf.total_exits !== 16'd0) begin
            fails++; $display("FAIL stats got entries=%0d exits=%0d want 1/0", intf.total_entries, intf.total_exits);
        end
`endif
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        intf.a = 2'b00;
        intf.b = 2'b00;
        test_reset();
        test_enter();
        test_abort_and_underflow();
        test_full();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parking_lot_occupancy.md
# parking_lot_occupancy

Multi-lane parking-lot occupancy tracker with a configurable capacity. Each lane has a two-sensor gate (outer sensor `a`, inner sensor `b`). A per-lane direction FSM turns the sensor sequence into single-cycle enter and exit events. A shared saturating counter sums these events into the current occupancy and drives full/empty flags. The block replaces the single inc/dec lot counter; it sits between the gate sensor synchronisers and the lot status display.

## Interface
Parameters:
- `CAPACITY`, 25: maximum occupancy; the count saturates here.
- `LANES`, 2: number of independent gates (1–8).
- `WIDTH`, `$clog2(CAPACITY+1)` (5 at default): width of `count`.

Ports:
- `clk`  in  1  sole clock; every flop is posedge `clk`.
- `reset`  in  1  synchronous, active-high; takes effect at the next posedge `clk`.
- `a`  in  LANES  outer sensor per lane; 1 = beam blocked. Already synchronised to `clk`.
- `b`  in  LANES  inner sensor per lane; 1 = beam blocked.
- `count`  out  WIDTH  current occupancy, 0..CAPACITY.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `lane_enter`  out  LANES  registered one-cycle pulse per completed entry.
- `lane_exit`  out  LANES  registered one-cycle pulse per completed exit.
- `rejected`  out  1  one-cycle pulse when saturation discards at least one event.

## Operation
- Each lane has its own FSM. The states are IDLE, EN1, EN2, EN3, EX1, EX2, EX3. The sensor sample is written as {a,b}.
- IDLE:
  - 10 goes to EN1.
  - 01 goes to EX1.
  - 00 and 11 stay in IDLE. 11 from IDLE is ambiguous and is ignored.
- EN1:
  - 11 goes to EN2.
  - 10 stays in EN1.
  - 00 goes to IDLE (car aborted, no event).
  - 01 goes to IDLE (illegal, no event).
- EN2:
  - 01 goes to EN3.
  - 10 goes back to EN1 (car reversing).
  - 11 stays in EN2.
  - 00 goes to IDLE with no event.
- EN3:
  - 00 goes to IDLE and produces an enter event.
  - 11 goes back to EN2.
  - 01 stays in EN3.
  - 10 goes to IDLE with no event.
- EX1, EX2, EX3 mirror EN1, EN2, EN3 with `a` and `b` swapped. EX3 followed by 00 produces an exit event.
- Count update:
  - delta = (number of enter events) − (number of exit events) over all lanes in the same cycle. Compute it signed, at width WIDTH+2.
  - next count = clamp(count + delta, 0, CAPACITY).
- `rejected` pulses when the unclamped sum is below 0 or above CAPACITY.
- `lane_enter` and `lane_exit` report every FSM event, including events the clamp absorbed.
- `full` and `empty` are decoded from the registered `count`, so they are glitch-free.

## Timing
- Reset values: all FSMs in IDLE, `count` = 0, `empty` = 1, `full` = 0, all pulses 0.
- Reset during a sequence abandons it with no event.
- After reset, a lane whose sensors are still blocked (11) stays in IDLE until it sees a valid start pattern.
- Latency: when the sample at edge k completes a sequence, at edge k:
  - `lane_enter` or `lane_exit` rises for exactly one cycle;
  - `count`, `full`, `empty` and `rejected` update at the same edge.
- A lane emits at most one event per cycle. Events from different lanes in the same cycle are all counted.
- Simultaneous enter on one lane and exit on another cancel out: `count` is unchanged and `rejected` = 0.
- With a full lot, another entry is still reported on `lane_enter`, `count` stays at CAPACITY, and `rejected` pulses. The same applies to an exit on an empty lot.
- A sensor pattern held for any number of cycles keeps the FSM in its current state; there is no timeout.

## Configuration
- `PARKING_LOT_STATS_EN`
  - Defined: adds output `total_entries` [15:0] and output `total_exits` [15:0].
    - Each is a free-running counter of `lane_enter` and `lane_exit` pulses respectively, summed across lanes, including rejected events.
    - They wrap modulo 2^16 and reset to 0.
  - Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset held for 3 cycles, then released → `count` = 0, `empty` = 1, `full` = 0, no pulses.
- Lane 0 driven 10, 11, 01, 00 on consecutive cycles → `lane_enter[0]` pulses once, at the edge that samples 00; `count` goes from 0 to 1 at that edge.
- Lane 0 driven 10, 11, 10, 00 (car backs out) → no pulse, `count` unchanged. Then an exit sequence 01, 11, 10, 00 from `count` = 0 → `lane_exit[0]` pulses, `count` stays 0, `rejected` pulses.
- `count` = 24, both lanes complete an entry in the same cycle → `count` = 25, `full` = 1, `rejected` = 1.
- `count` = 10, lane 0 completes an entry while lane 1 completes an exit in the same cycle → `count` = 10, both pulses seen, `rejected` = 0.
- Reset asserted while lane 1 is in EN2, then released with sensors at 11 → no event; a following 00, 10, 11, 01, 00 gives `count` = 1. With `PARKING_LOT_STATS_EN` defined, `total_entries` = 1.
